i2c_reg_seq: RTL and testbench



---
 rtl/i2c_pkg.sv | 13 +
 rtl/i2c_reg_seq.sv | 144 ++++++++++++++
 tb/tb_i2c_reg_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared encodings for the byte-level i2c_master core and its wrappers.
package i2c_pkg;

  localparam logic [1:0] I2C_CMD_START = 2'b00;
  localparam logic [1:0] I2C_CMD_STOP  = 2'b01;
  localparam logic [1:0] I2C_CMD_WRITE = 2'b10;
  localparam logic [1:0] I2C_CMD_READ  = 2'b11;

  // Ack bit polarity on the wire: low = ACK, high = NAK.
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NAK = 1'b1;

endpackage

// File: rtl/i2c_reg_seq.sv
// Register read/write transaction sequencer driving one i2c_master core
// through START / address / data / STOP command sequences.
module i2c_reg_seq
  import i2c_pkg::*;
#(
  parameter int unsigned RA_BYTES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rnw,
  input  logic [6:0]            req_dev,
  input  logic [8*RA_BYTES-1:0] req_reg,
  input  logic [7:0]            req_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic                  rsp_nak,
  output logic                  busy,
  output logic [1:0]            i2c_cmd,
  output logic                  i2c_stb,
  output logic [7:0]            i2c_data_in,
  output logic                  i2c_ack_in,
  input  logic [7:0]            i2c_data_out,
  input  logic                  i2c_ack_out,
  input  logic                  i2c_ready
);

  localparam int unsigned STEP_W = $clog2(7 + RA_BYTES);
  localparam logic [STEP_W-1:0] W_STOP = STEP_W'(3 + RA_BYTES);
  localparam logic [STEP_W-1:0] R_STOP = STEP_W'(5 + RA_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;

  state_e                  state, state_nx;
  logic [STEP_W-1:0]       step;
  logic                    rnw_r;
  logic [6:0]              dev_r;
  logic [8*RA_BYTES-1:0]   reg_r;
  logic [7:0]              wdata_r;
  logic                    ready_r;
  logic                    nak_r;
  logic [7:0]              rdata_r;
  logic [1:0]              cmd;
  logic [7:0]              data;
  logic [8*RA_BYTES-1:0]   reg_sh;
  int unsigned             s;
  logic                    issue_go;
  logic                    cmd_done;

  // Both ready and its delayed copy high means the previous command's
  // low phase is over, which keeps strobes at least two cycles apart.
  assign issue_go = (state == ST_ISSUE) && i2c_ready && ready_r;
  assign cmd_done = (state == ST_WAIT) && i2c_ready && !ready_r;

  always_comb begin
    cmd    = I2C_CMD_STOP;
    data   = '0;
    reg_sh = '0;
    s      = 32'(step);
    if (s == 0) begin
      cmd = I2C_CMD_START;
    end else if (s == 1) begin
      cmd  = I2C_CMD_WRITE;
      data = {dev_r, 1'b0};
    end else if (s < 2 + RA_BYTES) begin
      cmd    = I2C_CMD_WRITE;
      reg_sh = reg_r >> (8 * (RA_BYTES + 1 - s));
      data   = reg_sh[7:0];
    end else if (!rnw_r) begin
      if (s == 2 + RA_BYTES) begin
        cmd  = I2C_CMD_WRITE;
        data = wdata_r;
      end
    end else if (s == 2 + RA_BYTES) begin
      cmd = I2C_CMD_START;
    end else if (s == 3 + RA_BYTES) begin
      cmd  = I2C_CMD_WRITE;
      data = {dev_r, 1'b1};
    end else if (s == 4 + RA_BYTES) begin
      cmd = I2C_CMD_READ;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nx = ST_ISSUE;
      ST_ISSUE: if (issue_go) state_nx = ST_WAIT;
      ST_WAIT:  if (cmd_done) state_nx = (cmd == I2C_CMD_STOP) ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step    <= '0;
      rnw_r   <= 1'b0;
      dev_r   <= '0;
      reg_r   <= '0;
      wdata_r <= '0;
      ready_r <= 1'b0;
      nak_r   <= 1'b0;
      rdata_r <= '0;
    end else begin
      ready_r <= i2c_ready;
      if (state == ST_IDLE && req_valid) begin
        rnw_r   <= req_rnw;
        dev_r   <= req_dev;
        reg_r   <= req_reg;
        wdata_r <= req_wdata;
        step    <= '0;
        nak_r   <= 1'b0;
        rdata_r <= '0;
      end else if (cmd_done) begin
        // A NAKed write jumps straight to STOP so the bus is always released.
        if (cmd == I2C_CMD_WRITE && i2c_ack_out == I2C_NAK) begin
          nak_r <= 1'b1;
          step  <= rnw_r ? R_STOP : W_STOP;
        end else if (cmd != I2C_CMD_STOP) begin
          step <= step + STEP_W'(1);
          if (cmd == I2C_CMD_READ) rdata_r <= i2c_data_out;
        end
      end
    end
  end

  assign req_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign rsp_valid   = (state == ST_DONE);
  assign rsp_rdata   = rdata_r;
  assign rsp_nak     = nak_r;
  assign i2c_stb     = issue_go;
  assign i2c_cmd     = cmd;
  assign i2c_data_in = data;
  assign i2c_ack_in  = (cmd == I2C_CMD_READ) ? I2C_NAK : I2C_ACK;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq: RA_BYTES=1 and RA_BYTES=2 instances share
// one behavioural i2c_master model selected by sel.
module tb_i2c_reg_seq;
  import i2c_pkg::*;

  logic        clk, rst_n, sel;
  logic        req_valid, req_rnw;
  logic [6:0]  req_dev;
  logic [15:0] req_reg;
  logic [7:0]  req_wdata;
  logic        core_ready, core_ack_out;
  logic [7:0]  core_data_out;

  logic        req_ready1, rsp_valid1, rsp_nak1, busy1, stb1, ack_in1;
  logic [7:0]  rsp_rdata1, data_in1;
  logic [1:0]  cmd1;
  logic        req_ready2, rsp_valid2, rsp_nak2, busy2, stb2, ack_in2;
  logic [7:0]  rsp_rdata2, data_in2;
  logic [1:0]  cmd2;
  logic        req_valid1, req_valid2;

  assign req_valid1 = req_valid & ~sel;
  assign req_valid2 = req_valid & sel;

  i2c_reg_seq #(.RA_BYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_rnw(req_rnw), .req_dev(req_dev), .req_reg(req_reg[7:0]), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_nak(rsp_nak1), .busy(busy1),
    .i2c_cmd(cmd1), .i2c_stb(stb1), .i2c_data_in(data_in1), .i2c_ack_in(ack_in1),
    .i2c_data_out(core_data_out), .i2c_ack_out(core_ack_out), .i2c_ready(core_ready)
  );

  i2c_reg_seq #(.RA_BYTES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_rnw(req_rnw), .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_nak(rsp_nak2), .busy(busy2),
    .i2c_cmd(cmd2), .i2c_stb(stb2), .i2c_data_in(data_in2), .i2c_ack_in(ack_in2),
    .i2c_data_out(core_data_out), .i2c_ack_out(core_ack_out), .i2c_ready(core_ready)
  );

  logic       stb, busy, req_ready, rsp_valid, rsp_nak, ack_in;
  logic [1:0] cmd;
  logic [7:0] data_in, rsp_rdata;
  assign stb       = sel ? stb2       : stb1;
  assign busy      = sel ? busy2      : busy1;
  assign req_ready = sel ? req_ready2 : req_ready1;
  assign rsp_valid = sel ? rsp_valid2 : rsp_valid1;
  assign rsp_nak   = sel ? rsp_nak2   : rsp_nak1;
  assign rsp_rdata = sel ? rsp_rdata2 : rsp_rdata1;
  assign ack_in    = sel ? ack_in2    : ack_in1;
  assign cmd       = sel ? cmd2       : cmd1;
  assign data_in   = sel ? data_in2   : data_in1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Log entry: {cmd, ack_in, write byte or 0}
  function automatic logic [10:0] ent(input logic [1:0] c, input logic [7:0] d);
    ent = {c, (c == I2C_CMD_READ), (c == I2C_CMD_WRITE) ? d : 8'h00};
  endfunction

  logic [10:0] log_q[$];
  logic [10:0] exp_q[$];
  logic        nak_en;
  logic [7:0]  nak_byte, model_rdata;
  int          cnt, viol, rsp_cnt, acc_cnt;
  logic        stb_prev;
  logic [7:0]  last_rdata;
  logic        last_nak;

  // Core model: ready drops the cycle after stb and returns 4 cycles after it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ready    <= 1'b1;
      cnt           <= 0;
      core_ack_out  <= 1'b0;
      core_data_out <= 8'h00;
    end else if (stb) begin
      log_q.push_back({cmd, ack_in, (cmd == I2C_CMD_WRITE) ? data_in : 8'h00});
      core_ready <= 1'b0;
      cnt        <= 3;
      if (cmd == I2C_CMD_WRITE) core_ack_out <= nak_en && (data_in == nak_byte);
      if (cmd == I2C_CMD_READ)  core_data_out <= model_rdata;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) core_ready <= 1'b1;
    end
  end

  always @(posedge clk) begin
    viol     <= viol + ((stb && !core_ready) ? 1 : 0) + ((stb && stb_prev) ? 1 : 0);
    stb_prev <= stb;
    if (rsp_valid) begin
      rsp_cnt    <= rsp_cnt + 1;
      last_rdata <= rsp_rdata;
      last_nak   <= rsp_nak;
    end
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check_log(input string tag);
    check_eq({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check_eq($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  task automatic do_req(input logic rnw, input logic [6:0] dev, input logic [15:0] rg,
                        input logic [7:0] wd);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_cnt < target && n < 400) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
  endtask

  int base;

  initial begin
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_rnw = 1'b0;
    req_dev = '0; req_reg = '0; req_wdata = '0;
    nak_en = 1'b0; nak_byte = 8'h00; model_rdata = 8'h00;
    viol = 0; rsp_cnt = 0; acc_cnt = 0; stb_prev = 1'b0;
    last_rdata = 8'h00; last_nak = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_stb", stb, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_outs", {rsp_rdata, rsp_nak, cmd, data_in, ack_in}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write, RA_BYTES=1
    log_q.delete(); exp_q.delete();
    exp_q = '{ent(I2C_CMD_START, 0), ent(I2C_CMD_WRITE, 8'hA0), ent(I2C_CMD_WRITE, 8'h12),
              ent(I2C_CMD_WRITE, 8'hA5), ent(I2C_CMD_STOP, 0)};
    do_req(1'b0, 7'h50, 16'h0012, 8'hA5);
    check_eq("wr_busy", busy, 1);
    wait_rsp(1);
    check_log("wr1");
    check_eq("wr_rsp_cnt", rsp_cnt, 1);
    check_eq("wr_rdata", last_rdata, 8'h00);
    check_eq("wr_nak", last_nak, 0);
    check_eq("wr_idle", {busy, req_ready}, 2'b01);

    // Read, model returns 0x5C
    log_q.delete(); model_rdata = 8'h5C;
    exp_q = '{ent(I2C_CMD_START, 0), ent(I2C_CMD_WRITE, 8'hA0), ent(I2C_CMD_WRITE, 8'h34),
              ent(I2C_CMD_START, 0), ent(I2C_CMD_WRITE, 8'hA1), ent(I2C_CMD_READ, 0),
              ent(I2C_CMD_STOP, 0)};
    do_req(1'b1, 7'h50, 16'h0034, 8'h00);
    wait_rsp(2);
    check_log("rd");
    check_eq("rd_rsp_cnt", rsp_cnt, 2);
    check_eq("rd_rdata", last_rdata, 8'h5C);
    check_eq("rd_nak", last_nak, 0);
    check_eq("rd_rdata_held", rsp_rdata, 8'h5C);

    // Read with address byte NAKed
    log_q.delete(); nak_en = 1'b1; nak_byte = 8'h46;
    exp_q = '{ent(I2C_CMD_START, 0), ent(I2C_CMD_WRITE, 8'h46), ent(I2C_CMD_STOP, 0)};
    do_req(1'b1, 7'h23, 16'h0001, 8'h00);
    wait_rsp(3);
    check_log("nak");
    check_eq("nak_rsp_cnt", rsp_cnt, 3);
    check_eq("nak_rdata", last_rdata, 8'h00);
    check_eq("nak_flag", last_nak, 1);
    nak_en = 1'b0;

    // RA_BYTES=2 write
    sel = 1'b1;
    log_q.delete();
    exp_q = '{ent(I2C_CMD_START, 0), ent(I2C_CMD_WRITE, 8'hA0), ent(I2C_CMD_WRITE, 8'hBE),
              ent(I2C_CMD_WRITE, 8'hEF), ent(I2C_CMD_WRITE, 8'h01), ent(I2C_CMD_STOP, 0)};
    do_req(1'b0, 7'h50, 16'hBEEF, 8'h01);
    wait_rsp(4);
    check_log("ra2");
    check_eq("ra2_rsp_cnt", rsp_cnt, 4);
    check_eq("ra2_nak", last_nak, 0);
    sel = 1'b0;
    @(negedge clk);

    // Three queued writes with req_valid held high
    log_q.delete(); exp_q.delete();
    base = acc_cnt;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ent(I2C_CMD_START, 0));
      exp_q.push_back(ent(I2C_CMD_WRITE, 8'(8'h20 + 2 * k)));
      exp_q.push_back(ent(I2C_CMD_WRITE, 8'(k + 1)));
      exp_q.push_back(ent(I2C_CMD_WRITE, 8'(8'h11 * (k + 1))));
      exp_q.push_back(ent(I2C_CMD_STOP, 0));
    end
    req_valid = 1'b1; req_rnw = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int n;
      req_dev = 7'(8'h10 + k); req_reg = 16'(k + 1); req_wdata = 8'(8'h11 * (k + 1));
      n = 0;
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    wait_rsp(7);
    check_log("q");
    check_eq("q_rsp_cnt", rsp_cnt, 7);
    check_eq("q_accepts", acc_cnt - base, 3);
    check_eq("stb_rules", viol, 0);

    // Reset during WAIT of the data byte
    log_q.delete();
    base = rsp_cnt;
    begin
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_rnw = 1'b0; req_dev = 7'h50; req_reg = 16'h0012; req_wdata = 8'h77;
      n = 0;
      while (log_q.size() < 4 && n < 200) begin @(negedge clk); n++; req_valid = 1'b0; end
    end
    @(negedge clk);
    check_eq("mid_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check_eq("arst_stb", stb, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("arst_no_rsp", rsp_cnt, base);
    log_q.delete();
    exp_q = '{ent(I2C_CMD_START, 0), ent(I2C_CMD_WRITE, 8'hA0), ent(I2C_CMD_WRITE, 8'h12),
              ent(I2C_CMD_WRITE, 8'h77), ent(I2C_CMD_STOP, 0)};
    do_req(1'b0, 7'h50, 16'h0012, 8'h77);
    wait_rsp(base + 1);
    check_log("post_rst");
    check_eq("post_rst_rsp", rsp_cnt, base + 1);
    check_eq("post_rst_nak", last_nak, 0);
    check_eq("stb_rules_final", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
